// File: rtl/rf_dump.sv
// Debug scan initiator: walks every register of the RF through one read port and
// streams each word (plus an optional wrapping checksum) over a valid/ready link.
module rf_dump #(
    parameter int WIDTH     = 16,
    parameter int NUM_REGS  = 8,
    parameter int SELW      = 3,
    parameter int SEND_CSUM = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [SELW-1:0]  rf_regsel,
    input  logic [WIDTH-1:0] rf_rdata,
    output logic [WIDTH-1:0] out_data,
    output logic [SELW:0]    out_idx,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic             busy,
    output logic             done,
    output logic             err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SEND,
        S_CSUM,
        S_DONE
    } state_t;

    localparam logic [SELW-1:0] LAST_IDX = SELW'(NUM_REGS - 1);
    localparam logic [SELW:0]   CSUM_IDX = (SELW + 1)'(NUM_REGS);
    localparam logic            HAS_CSUM = (SEND_CSUM != 0);

    state_t           state_q, state_d;
    logic [SELW-1:0]  idx_q, idx_d;
    logic [SELW-1:0]  regsel_q, regsel_d;
    logic [WIDTH-1:0] csum_q, csum_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [SELW:0]    out_idx_q, out_idx_d;
    logic             out_valid_q, out_valid_d;
    logic             out_last_q, out_last_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic handshake;
    assign handshake = out_valid_q & out_ready;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        regsel_d    = regsel_q;
        csum_d      = csum_q;
        out_data_d  = out_data_q;
        out_idx_d   = out_idx_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_LOAD;
                    idx_d    = '0;
                    regsel_d = '0;
                    csum_d   = '0;
                    busy_d   = 1'b1;
                end
            end
            S_LOAD: begin
                err_d       = start;
                out_data_d  = rf_rdata;
                out_idx_d   = {1'b0, idx_q};
                csum_d      = csum_q + rf_rdata;
                out_valid_d = 1'b1;
                out_last_d  = (idx_q == LAST_IDX) && !HAS_CSUM;
                state_d     = S_SEND;
            end
            S_SEND: begin
                err_d = start;
                if (handshake) begin
                    if (idx_q != LAST_IDX) begin
                        out_valid_d = 1'b0;
                        idx_d       = idx_q + SELW'(1);
                        regsel_d    = idx_q + SELW'(1);
                        state_d     = S_LOAD;
                    end else if (HAS_CSUM) begin
                        // Checksum is presented straight away so valid stays high across the boundary
                        out_data_d  = csum_q;
                        out_idx_d   = CSUM_IDX;
                        out_last_d  = 1'b1;
                        out_valid_d = 1'b1;
                        state_d     = S_CSUM;
                    end else begin
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                        done_d      = 1'b1;
                        state_d     = S_DONE;
                    end
                end
            end
            S_CSUM: begin
                err_d = start;
                if (handshake) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    done_d      = 1'b1;
                    state_d     = S_DONE;
                end
            end
            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            regsel_q    <= '0;
            csum_q      <= '0;
            out_data_q  <= '0;
            out_idx_q   <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            regsel_q    <= regsel_d;
            csum_q      <= csum_d;
            out_data_q  <= out_data_d;
            out_idx_q   <= out_idx_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign rf_regsel = regsel_q;
    assign out_data  = out_data_q;
    assign out_idx   = out_idx_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_rf_dump.sv
// Self-checking bench for rf_dump: table-driven dumps, random backpressure against a
// queue-based stream model, plus hand sequences for err, reset and write coherency.
module tb_rf_dump;

    typedef struct packed {
        logic [3:0]  idx;
        logic [15:0] data;
        logic        last;
    } word_t;

    typedef struct {
        logic [15:0] base;
        logic [15:0] step;
        int          mode;
        logic [15:0] exp_csum;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst, start, start1, out_ready;
    logic        out_ready1 = 1'b1;
    logic [15:0] rf [8];
    logic [2:0]  rf_regsel, rf_regsel1;
    logic [15:0] rf_rdata, rf_rdata1;
    logic [15:0] out_data, out_data1;
    logic [3:0]  out_idx, out_idx1;
    logic        out_valid, out_last, busy, done, err;
    logic        out_valid1, out_last1, busy1, done1, err1;

    int checks = 0;
    int fails  = 0;
    int done_cnt = 0, err_cnt = 0, done1_cnt = 0;
    int err_at = -1;
    int wr_at  = -1;
    word_t got_q[$], got1_q[$], exp_q[$];
    logic        hold_pend = 1'b0;
    logic [21:0] hold_word;

    always #5 clk = ~clk;

    assign rf_rdata  = rf[rf_regsel];
    assign rf_rdata1 = rf[rf_regsel1];

    rf_dump #(.WIDTH(16), .NUM_REGS(8), .SELW(3), .SEND_CSUM(1)) dut (
        .clk(clk), .rst(rst), .start(start), .rf_regsel(rf_regsel), .rf_rdata(rf_rdata),
        .out_data(out_data), .out_idx(out_idx), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .busy(busy), .done(done), .err(err)
    );

    rf_dump #(.WIDTH(16), .NUM_REGS(8), .SELW(3), .SEND_CSUM(0)) dut_nocsum (
        .clk(clk), .rst(rst), .start(start1), .rf_regsel(rf_regsel1), .rf_rdata(rf_rdata1),
        .out_data(out_data1), .out_idx(out_idx1), .out_valid(out_valid1), .out_ready(out_ready1),
        .out_last(out_last1), .busy(busy1), .done(done1), .err(err1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Handshake monitor and stall-stability checker, sampled mid-cycle
    always @(negedge clk) begin
        if (!rst) begin
            if (hold_pend)
                check("hold_stable", {10'd0, out_valid, out_idx, out_data, out_last}, {10'd0, hold_word});
            hold_pend = out_valid && !out_ready;
            hold_word = {out_valid, out_idx, out_data, out_last};
            if (out_valid && out_ready)   got_q.push_back('{out_idx, out_data, out_last});
            if (out_valid1 && out_ready1) got1_q.push_back('{out_idx1, out_data1, out_last1});
            if (done)  done_cnt++;
            if (err)   err_cnt++;
            if (done1) done1_cnt++;
        end else begin
            hold_pend = 1'b0;
        end
    end

    // Reference: the stream is every register in order, then the 16-bit wrapped sum
    task automatic build_exp(input logic [15:0] snap [8], input bit csum_en);
        int unsigned s = 0;
        exp_q.delete();
        for (int i = 0; i < 8; i++) begin
            s += snap[i];
            exp_q.push_back('{4'(i), snap[i], (i == 7) && !csum_en});
        end
        if (csum_en) exp_q.push_back('{4'd8, 16'(s % 65536), 1'b1});
    endtask

    task automatic compare_stream(input string name, input bit which);
        word_t g[$];
        if (which) g = got1_q;
        else       g = got_q;
        check({name, "_count"}, g.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < g.size(); i++)
            check($sformatf("%s_w%0d", name, i), {11'd0, g[i]}, {11'd0, exp_q[i]});
    endtask

    // mode 0: always ready, 1: random ready, 2: ready low 3 cycles at each word
    task automatic run_dump(input int mode);
        int  wc = 0, cyc = 0, last_hs = -10;
        bit  fin = 0, inj = 0, wrote = 0, wr_now = 0;
        got_q.delete();
        @(posedge clk); #1 start = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1 start = 1'b0;
        check("start_busy", busy, 1'b1);
        check("start_regsel", rf_regsel, 3'd0);
        check("start_valid_low", out_valid, 1'b0);
        while (!fin && cyc < 400) begin
            case (mode)
                0: out_ready = 1'b1;
                1: out_ready = 1'($urandom_range(0, 1));
                default: begin
                    if (out_valid) begin
                        if (wc < 3) begin out_ready = 1'b0; wc++; end
                        else        begin out_ready = 1'b1; wc = 0; end
                    end else out_ready = 1'b0;
                end
            endcase
            if (cyc == 1) check("latency_first_word", {out_valid, out_idx}, {1'b1, 4'd0});
            if (err_at >= 0 && !inj && out_valid && out_idx == 4'(err_at)) begin
                start = 1'b1; inj = 1;
            end else start = 1'b0;
            if (wr_at >= 0 && !wrote && busy && !out_valid && rf_regsel == 3'(wr_at)) wr_now = 1;
            if (done) begin
                fin = 1;
                check("done_after_last_hs", cyc - last_hs, 1);
            end
            if (out_valid && out_ready) last_hs = cyc;
            if (!fin) begin
                @(posedge clk);
                if (wr_now) begin rf[wr_at] <= 16'hBEEF; wrote = 1; wr_now = 0; end
                #1;
                cyc++;
            end
        end
        if (!fin) check("done_timeout", 0, 1);
        start = 1'b0;
        @(posedge clk); #1;
        check("busy_clear", busy, 1'b0);
    endtask

    initial begin
        vec_t        vecs [5];
        logic [15:0] snap [8];
        int          d0, e0, k;
        bit          found;

        vecs[0] = '{16'h0000, 16'h1001, 0, 16'hC01C};
        vecs[1] = '{16'h0000, 16'h1001, 2, 16'hC01C};
        vecs[2] = '{16'hFFFF, 16'h0000, 0, 16'hFFF8};
        vecs[3] = '{16'h8000, 16'h8000, 1, 16'h0000};
        vecs[4] = '{16'h1234, 16'h1111, 2, 16'h6F7C};

        rst = 1'b1; start = 1'b0; start1 = 1'b0; out_ready = 1'b0;
        for (int i = 0; i < 8; i++) rf[i] = 16'h0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_regsel", rf_regsel, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_idx", out_idx, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_last", out_last, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        rst = 1'b0;

        foreach (vecs[v]) begin
            for (int i = 0; i < 8; i++) rf[i] = vecs[v].base + 16'(i) * vecs[v].step;
            snap = rf;
            d0 = done_cnt; e0 = err_cnt;
            run_dump(vecs[v].mode);
            build_exp(snap, 1'b1);
            compare_stream($sformatf("vec%0d", v), 1'b0);
            if (got_q.size() > 8) check($sformatf("vec%0d_csum", v), got_q[8].data, vecs[v].exp_csum);
            else                  check($sformatf("vec%0d_csum_missing", v), got_q.size(), 9);
            check($sformatf("vec%0d_done_pulses", v), done_cnt - d0, 1);
            check($sformatf("vec%0d_no_err", v), err_cnt - e0, 0);
        end

        for (int i = 0; i < 8; i++) rf[i] = 16'(i) * 16'h1001;
        snap = rf;
        e0 = err_cnt; err_at = 3;
        run_dump(0);
        err_at = -1;
        build_exp(snap, 1'b1);
        compare_stream("err_stream", 1'b0);
        check("err_one_cycle", err_cnt - e0, 1);

        got_q.delete();
        @(posedge clk); #1 start = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        found = 0; k = 0;
        while (!found && k < 100) begin
            if (out_valid && out_idx == 4'd5) found = 1;
            else begin @(posedge clk); #1; k++; end
        end
        check("rst_mid_found_word5", found, 1);
        out_ready = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        check("rst_mid_valid", out_valid, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_regsel", rf_regsel, 0);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) rf[i] = 16'h0101 * 16'(i + 1);
        snap = rf;
        run_dump(0);
        build_exp(snap, 1'b1);
        compare_stream("after_rst", 1'b0);

        for (int i = 0; i < 8; i++) rf[i] = 16'(i) * 16'h1001;
        snap = rf;
        wr_at = 4;
        run_dump(0);
        wr_at = -1;
        build_exp(snap, 1'b1);
        compare_stream("coherent_old", 1'b0);
        snap = rf;
        run_dump(0);
        build_exp(snap, 1'b1);
        compare_stream("coherent_new", 1'b0);
        if (got_q.size() > 4) check("coherent_new_reg4", got_q[4].data, 16'hBEEF);
        else                  check("coherent_new_size", got_q.size(), 9);

        for (int r = 0; r < 20; r++) begin
            for (int i = 0; i < 8; i++) rf[i] = 16'($urandom);
            snap = rf;
            run_dump(1);
            build_exp(snap, 1'b1);
            compare_stream($sformatf("rand%0d", r), 1'b0);
        end

        for (int i = 0; i < 8; i++) rf[i] = 16'(i) * 16'h1001;
        snap = rf;
        got1_q.delete(); d0 = done1_cnt;
        @(posedge clk); #1 start1 = 1'b1;
        @(posedge clk); #1 start1 = 1'b0;
        k = 0;
        while (!done1 && k < 100) begin @(posedge clk); #1; k++; end
        check("nocsum_done_seen", done1, 1);
        @(posedge clk); #1;
        build_exp(snap, 1'b0);
        compare_stream("nocsum", 1'b1);
        check("nocsum_done_pulses", done1_cnt - d0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
